// File: rtl/mem_lsu_pkg.sv
// Shared encodings and defaults for the memory-stage load/store unit.
// Load/store type codes, FSM states, bus timeout default and the alignment rule.
package mem_lsu_pkg;

    localparam int LSU_DATA_W      = 32;
    localparam int LSU_ADDR_W      = 32;
    localparam int LSU_BUS_TIMEOUT = 255;

    typedef enum logic [2:0] {
        LD_NONE = 3'd0,
        LD_LB   = 3'd1,
        LD_LH   = 3'd2,
        LD_LW   = 3'd3,
        LD_LBU  = 3'd4,
        LD_LHU  = 3'd5
    } ld_type_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'd0,
        ST_SB   = 2'd1,
        ST_SH   = 2'd2,
        ST_SW   = 2'd3
    } st_type_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    // Halfword ops need addr[0]==0, word ops need addr[1:0]==0; stores win over loads.
    function automatic logic lsu_misaligned(input logic is_store, input st_type_e st,
                                            input ld_type_e ld, input logic [1:0] lo);
        if (is_store)
            return ((st == ST_SH) && lo[0]) || ((st == ST_SW) && (lo != 2'b00));
        return (((ld == LD_LH) || (ld == LD_LHU)) && lo[0]) || ((ld == LD_LW) && (lo != 2'b00));
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Single-beat request/response data-cache bus between the LSU (master) and the cache (slave).
interface mem_lsu_if #(
    parameter int AW = 32,
    parameter int DW = 32
) ();
    logic          Dcache_Req;
    logic          Dcache_We;
    logic [AW-1:0] Dcache_Addr;
    logic [DW-1:0] Dcache_WrData;
    logic [3:0]    Dcache_WrStrb;
    logic          Dcache_Ready;
    logic          Dcache_RdValid;
    logic [DW-1:0] Dcache_RdData;

    modport master (
        output Dcache_Req, Dcache_We, Dcache_Addr, Dcache_WrData, Dcache_WrStrb,
        input  Dcache_Ready, Dcache_RdValid, Dcache_RdData
    );

    modport slave (
        input  Dcache_Req, Dcache_We, Dcache_Addr, Dcache_WrData, Dcache_WrStrb,
        output Dcache_Ready, Dcache_RdValid, Dcache_RdData
    );
endinterface

// File: rtl/mem_lsu_ld_align.sv
// Load-data extraction: picks the addressed byte/half out of the bus word and extends it.
// Purely combinational so the writeback path can reuse it on its own registered data.
module lsu_ld_align
    import mem_lsu_pkg::*;
(
    input  logic [31:0] i_rd_data,
    input  logic [1:0]  i_addr_lo,
    input  ld_type_e    i_ld_type,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rd_data[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rd_data[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_ld_data = 32'd0;
        case (i_ld_type)
            LD_LB:   o_ld_data = {{24{w_byte[7]}}, w_byte};
            LD_LBU:  o_ld_data = {24'd0, w_byte};
            LD_LH:   o_ld_data = {{16{w_half[15]}}, w_half};
            LD_LHU:  o_ld_data = {16'd0, w_half};
            LD_LW:   o_ld_data = i_rd_data;
            default: o_ld_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: alignment check, store lane steering, one outstanding
// data-cache transaction with timeout, and load extraction into a registered result.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_WIDTH  = LSU_DATA_W,
    parameter int ADDR_WIDTH  = LSU_ADDR_W,
    parameter int BUS_TIMEOUT = LSU_BUS_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  EX_LdStFlag,
    input  logic [ADDR_WIDTH-1:0] EX_AluData,
    input  logic [DATA_WIDTH-1:0] EX_StData,
    input  logic [2:0]            EX_LdType,
    input  logic [1:0]            EX_StType,
    input  logic                  Pipe_Flush,
    mem_lsu_if.master             dc,
    output logic [DATA_WIDTH-1:0] MEM_LdData,
    output logic                  MEM_LdValid,
    output logic                  MEM_Misalign,
    output logic                  MEM_AccessFault,
    output logic [ADDR_WIDTH-1:0] MEM_BadAddr,
    output logic                  LSU_Stall
);

    lsu_state_e            r_state;
    logic                  r_req;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [ADDR_WIDTH-1:0] r_addr_full;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_strb;
    logic [1:0]            r_addr_lo;
    ld_type_e              r_ld_type;
    logic                  r_is_load;
    logic                  r_kill;
    logic [7:0]            r_cnt;
    logic [DATA_WIDTH-1:0] r_ld_data;
    logic                  r_ld_valid;
    logic                  r_misalign;
    logic                  r_fault;
    logic [ADDR_WIDTH-1:0] r_bad_addr;

    st_type_e              w_st_type;
    ld_type_e              w_ld_type;
    logic                  w_is_store;
    logic                  w_is_load;
    logic                  w_start;
    logic                  w_misalign;
    logic                  w_go;
    logic                  w_bad;
    logic [3:0]            w_byte_strb;
    logic [3:0]            w_strb;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_ld_data;

    assign w_st_type  = st_type_e'(EX_StType);
    assign w_ld_type  = ld_type_e'(EX_LdType);
    assign w_is_store = (w_st_type != ST_NONE);
    assign w_is_load  = !w_is_store && (EX_LdType >= 3'd1) && (EX_LdType <= 3'd5);

    assign w_start    = EX_LdStFlag && !Pipe_Flush && (w_is_store || w_is_load) &&
                        ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_misalign = lsu_misaligned(w_is_store, w_st_type, w_ld_type, EX_AluData[1:0]);
    assign w_go       = w_start && !w_misalign;
    assign w_bad      = w_start && w_misalign;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign w_byte_strb[gi] = (EX_AluData[1:0] == 2'(gi));
        end
    endgenerate

    always_comb begin
        w_strb  = 4'b0000;
        w_wdata = '0;
        case (w_st_type)
            ST_SB: begin
                w_strb  = w_byte_strb;
                w_wdata = {4{EX_StData[7:0]}};
            end
            ST_SH: begin
                w_strb  = EX_AluData[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{EX_StData[15:0]}};
            end
            ST_SW: begin
                w_strb  = 4'b1111;
                w_wdata = EX_StData;
            end
            default: begin
                w_strb  = 4'b0000;
                w_wdata = '0;
            end
        endcase
    end

    lsu_ld_align u_ld_align (
        .i_rd_data (dc.Dcache_RdData),
        .i_addr_lo (r_addr_lo),
        .i_ld_type (r_ld_type),
        .o_ld_data (w_ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_req       <= 1'b0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_addr_full <= '0;
            r_wdata     <= '0;
            r_strb      <= 4'b0000;
            r_addr_lo   <= 2'b00;
            r_ld_type   <= LD_NONE;
            r_is_load   <= 1'b0;
            r_kill      <= 1'b0;
            r_cnt       <= 8'd0;
            r_ld_data   <= '0;
            r_ld_valid  <= 1'b0;
            r_misalign  <= 1'b0;
            r_fault     <= 1'b0;
            r_bad_addr  <= '0;
        end else begin
            r_ld_valid <= 1'b0;
            r_misalign <= 1'b0;
            r_fault    <= 1'b0;

            if (w_bad) begin
                r_misalign <= 1'b1;
                r_bad_addr <= EX_AluData;
            end

            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_go) begin
                        r_state     <= S_REQ;
                        r_req       <= 1'b1;
                        r_we        <= w_is_store;
                        r_addr      <= {EX_AluData[ADDR_WIDTH-1:2], 2'b00};
                        r_addr_full <= EX_AluData;
                        r_wdata     <= w_wdata;
                        r_strb      <= w_strb;
                        r_addr_lo   <= EX_AluData[1:0];
                        r_ld_type   <= w_is_load ? w_ld_type : LD_NONE;
                        r_is_load   <= w_is_load;
                        r_kill      <= 1'b0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_REQ: begin
                    // Acceptance beats a simultaneous flush; the flush then only kills the result.
                    if (dc.Dcache_Ready) begin
                        r_req   <= 1'b0;
                        r_state <= S_WAIT;
                        r_cnt   <= 8'd0;
                        r_kill  <= Pipe_Flush;
                    end else if (Pipe_Flush) begin
                        r_req   <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (Pipe_Flush)
                        r_kill <= 1'b1;
                    if (dc.Dcache_RdValid) begin
                        r_state <= S_DONE;
                        if (r_is_load) begin
                            r_ld_data  <= w_ld_data;
                            r_ld_valid <= !(r_kill || Pipe_Flush);
                        end
                    end else if (r_cnt == 8'(BUS_TIMEOUT - 1)) begin
                        r_fault    <= 1'b1;
                        r_bad_addr <= r_addr_full;
                        r_state    <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign dc.Dcache_Req     = r_req;
    assign dc.Dcache_We      = r_we;
    assign dc.Dcache_Addr    = r_addr;
    assign dc.Dcache_WrData  = r_wdata;
    assign dc.Dcache_WrStrb  = r_strb;

    assign MEM_LdData      = r_ld_data;
    assign MEM_LdValid     = r_ld_valid;
    assign MEM_Misalign    = r_misalign;
    assign MEM_AccessFault = r_fault;
    assign MEM_BadAddr     = r_bad_addr;
    assign LSU_Stall       = (r_state == S_REQ) || (r_state == S_WAIT) || w_go;

endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: directed ops push expected bus requests and results,
// a negedge monitor pops and compares whenever the DUT presents them.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        EX_LdStFlag;
    logic [31:0] EX_AluData;
    logic [31:0] EX_StData;
    logic [2:0]  EX_LdType;
    logic [1:0]  EX_StType;
    logic        Pipe_Flush;
    logic [31:0] MEM_LdData;
    logic        MEM_LdValid;
    logic        MEM_Misalign;
    logic        MEM_AccessFault;
    logic [31:0] MEM_BadAddr;
    logic        LSU_Stall;

    mem_lsu_if #(.AW(32), .DW(32)) dc ();

    mem_lsu #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .BUS_TIMEOUT(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .EX_LdStFlag     (EX_LdStFlag),
        .EX_AluData      (EX_AluData),
        .EX_StData       (EX_StData),
        .EX_LdType       (EX_LdType),
        .EX_StType       (EX_StType),
        .Pipe_Flush      (Pipe_Flush),
        .dc              (dc),
        .MEM_LdData      (MEM_LdData),
        .MEM_LdValid     (MEM_LdValid),
        .MEM_Misalign    (MEM_Misalign),
        .MEM_AccessFault (MEM_AccessFault),
        .MEM_BadAddr     (MEM_BadAddr),
        .LSU_Stall       (LSU_Stall)
    );

    always #5 clk = ~clk;

    typedef logic [68:0] req_t;   // {We, Addr, WrData, WrStrb}
    req_t        req_q[$];
    logic [31:0] ld_q[$];
    logic [31:0] mis_q[$];
    logic [31:0] flt_q[$];

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;
    int req_cycles = 0;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic unexpected(input string name, input logic [68:0] act);
        checks++;
        errors++;
        $display("FAIL %s act=%0h exp=none", name, act);
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        if (!rst) begin
            if (dc.Dcache_Req) begin
                req_cycles++;
                if (req_q.size() == 0)
                    unexpected("unexpected_req", {dc.Dcache_We, dc.Dcache_Addr, dc.Dcache_WrData, dc.Dcache_WrStrb});
                else begin
                    chk("req_fields", {dc.Dcache_We, dc.Dcache_Addr, dc.Dcache_WrData, dc.Dcache_WrStrb}, req_q[0]);
                    if (dc.Dcache_Ready) begin
                        $display("REQ we=%0b addr=%h wdata=%h strb=%b", dc.Dcache_We, dc.Dcache_Addr,
                                 dc.Dcache_WrData, dc.Dcache_WrStrb);
                        req_q.delete(0);
                    end
                end
            end
            if (MEM_LdValid) begin
                if (ld_q.size() == 0)
                    unexpected("unexpected_ldvalid", {37'd0, MEM_LdData});
                else begin
                    $display("LOAD data=%h exp=%h", MEM_LdData, ld_q[0]);
                    chk("ld_data", {37'd0, MEM_LdData}, {37'd0, ld_q[0]});
                    ld_q.delete(0);
                end
            end
            if (MEM_Misalign) begin
                if (mis_q.size() == 0)
                    unexpected("unexpected_misalign", {37'd0, MEM_BadAddr});
                else begin
                    $display("MISALIGN badaddr=%h exp=%h", MEM_BadAddr, mis_q[0]);
                    chk("misalign_badaddr", {37'd0, MEM_BadAddr}, {37'd0, mis_q[0]});
                    mis_q.delete(0);
                end
            end
            if (MEM_AccessFault) begin
                if (flt_q.size() == 0)
                    unexpected("unexpected_fault", {37'd0, MEM_BadAddr});
                else begin
                    $display("FAULT badaddr=%h exp=%h", MEM_BadAddr, flt_q[0]);
                    chk("fault_badaddr", {37'd0, MEM_BadAddr}, {37'd0, flt_q[0]});
                    flt_q.delete(0);
                end
            end
            if (LSU_Stall)
                stall_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic start_op(input logic [2:0] ld, input logic [1:0] st,
                            input logic [31:0] addr, input logic [31:0] sd);
        EX_LdStFlag = 1'b1;
        EX_LdType   = ld;
        EX_StType   = st;
        EX_AluData  = addr;
        EX_StData   = sd;
        tick();
        EX_LdStFlag = 1'b0;
        EX_LdType   = 3'd0;
        EX_StType   = 2'd0;
    endtask

    task automatic run_op(input logic [2:0] ld, input logic [1:0] st, input logic [31:0] addr,
                          input logic [31:0] sd, input int rdy_dly, input int rv_dly,
                          input logic [31:0] rdata);
        start_op(ld, st, addr, sd);
        repeat (rdy_dly) tick();
        dc.Dcache_Ready = 1'b1;
        tick();
        dc.Dcache_Ready = 1'b0;
        repeat (rv_dly - 1) tick();
        dc.Dcache_RdValid = 1'b1;
        dc.Dcache_RdData  = rdata;
        tick();
        dc.Dcache_RdValid = 1'b0;
        tick();
    endtask

    logic [2:0]  t2_type [4] = '{3'd1, 3'd4, 3'd2, 3'd5};
    logic [31:0] t2_addr [4] = '{32'h1003, 32'h1003, 32'h1002, 32'h1000};
    logic [31:0] t2_exp  [4] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h00001234};

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        EX_LdStFlag = 1'b0; EX_AluData = '0; EX_StData = '0; EX_LdType = '0; EX_StType = '0;
        Pipe_Flush = 1'b0;
        dc.Dcache_Ready = 1'b0; dc.Dcache_RdValid = 1'b0; dc.Dcache_RdData = '0;
        repeat (3) tick();
        chk("rst_req", {68'd0, dc.Dcache_Req}, 69'd0);
        chk("rst_bus", {dc.Dcache_We, dc.Dcache_Addr, dc.Dcache_WrData, dc.Dcache_WrStrb}, 69'd0);
        chk("rst_mem", {MEM_LdValid, MEM_Misalign, MEM_AccessFault, LSU_Stall, MEM_LdData, MEM_BadAddr}, 69'd0);
        rst = 1'b0;
        tick();

        // 1: LW, Ready immediate, RdValid two WAIT cycles later
        stall_cnt = 0; req_cycles = 0;
        req_q.push_back({1'b0, 32'h1000, 32'h0, 4'b0000});
        ld_q.push_back(32'hDEADBEEF);
        run_op(3'd3, 2'd0, 32'h1000, 32'h0, 0, 2, 32'hDEADBEEF);
        tick();
        chk("t1_stall_cycles", 69'(stall_cnt), 69'd4);
        chk("t1_req_cycles", 69'(req_cycles), 69'd1);

        // 2: sub-word load extraction
        for (int i = 0; i < 4; i++) begin
            req_q.push_back({1'b0, 32'h1000, 32'h0, 4'b0000});
            ld_q.push_back(t2_exp[i]);
            run_op(t2_type[i], 2'd0, t2_addr[i], 32'h0, 0, 1, 32'h80FF1234);
        end

        // 3: SH upper half, Ready delayed 3 cycles
        req_cycles = 0;
        req_q.push_back({1'b1, 32'h2000, 32'hABCDABCD, 4'b1100});
        run_op(3'd0, 2'd2, 32'h2002, 32'h0000ABCD, 3, 1, 32'h0);
        chk("t3_req_cycles", 69'(req_cycles), 69'd4);

        // 4: misaligned LW and SH
        stall_cnt = 0; req_cycles = 0;
        mis_q.push_back(32'h1001);
        start_op(3'd3, 2'd0, 32'h1001, 32'h0);
        tick();
        mis_q.push_back(32'h1003);
        start_op(3'd0, 2'd2, 32'h1003, 32'h1234);
        tick();
        chk("t4_badaddr_held", {37'd0, MEM_BadAddr}, {37'd0, 32'h1003});
        chk("t4_stall_cycles", 69'(stall_cnt), 69'd0);
        chk("t4_req_cycles", 69'(req_cycles), 69'd0);

        // 5: bus timeout after 4 WAIT cycles, then a normal LW
        stall_cnt = 0;
        req_q.push_back({1'b0, 32'h3000, 32'h0, 4'b0000});
        flt_q.push_back(32'h3000);
        start_op(3'd3, 2'd0, 32'h3000, 32'h0);
        dc.Dcache_Ready = 1'b1;
        tick();
        dc.Dcache_Ready = 1'b0;
        repeat (4) tick();
        chk("t5_fault_pulse", {68'd0, MEM_AccessFault}, 69'd1);
        chk("t5_stall_low", {68'd0, LSU_Stall}, 69'd0);
        tick();
        chk("t5_stall_cycles", 69'(stall_cnt), 69'd6);
        req_q.push_back({1'b0, 32'h1000, 32'h0, 4'b0000});
        ld_q.push_back(32'h12345678);
        run_op(3'd3, 2'd0, 32'h1000, 32'h0, 0, 1, 32'h12345678);

        // 6a: flush in REQ before acceptance
        req_q.push_back({1'b0, 32'h1000, 32'h0, 4'b0000});
        start_op(3'd3, 2'd0, 32'h1000, 32'h0);
        Pipe_Flush = 1'b1;
        tick();
        Pipe_Flush = 1'b0;
        chk("t6a_req_dropped", {68'd0, dc.Dcache_Req}, 69'd0);
        chk("t6a_stall_low", {68'd0, LSU_Stall}, 69'd0);
        if (req_q.size() > 0) req_q.delete(0);
        tick();

        // 6b: flush in WAIT, response still consumed, no LdValid
        req_q.push_back({1'b0, 32'h1000, 32'h0, 4'b0000});
        start_op(3'd3, 2'd0, 32'h1000, 32'h0);
        dc.Dcache_Ready = 1'b1;
        tick();
        dc.Dcache_Ready = 1'b0;
        Pipe_Flush = 1'b1;
        tick();
        Pipe_Flush = 1'b0;
        dc.Dcache_RdValid = 1'b1; dc.Dcache_RdData = 32'hCAFEF00D;
        tick();
        dc.Dcache_RdValid = 1'b0;
        chk("t6b_no_ldvalid", {68'd0, MEM_LdValid}, 69'd0);
        tick();
        chk("t6b_stall_low", {68'd0, LSU_Stall}, 69'd0);

        // 6c: Ready and Flush together, accept wins but result is killed
        req_q.push_back({1'b0, 32'h1000, 32'h0, 4'b0000});
        start_op(3'd3, 2'd0, 32'h1000, 32'h0);
        dc.Dcache_Ready = 1'b1; Pipe_Flush = 1'b1;
        tick();
        dc.Dcache_Ready = 1'b0; Pipe_Flush = 1'b0;
        chk("t6c_still_waiting", {68'd0, LSU_Stall}, 69'd1);
        dc.Dcache_RdValid = 1'b1; dc.Dcache_RdData = 32'h11112222;
        tick();
        dc.Dcache_RdValid = 1'b0;
        chk("t6c_no_ldvalid", {68'd0, MEM_LdValid}, 69'd0);
        tick();

        // 6d: reset while in WAIT
        req_q.push_back({1'b0, 32'h1000, 32'h0, 4'b0000});
        start_op(3'd3, 2'd0, 32'h1000, 32'h0);
        dc.Dcache_Ready = 1'b1;
        tick();
        dc.Dcache_Ready = 1'b0;
        rst = 1'b1;
        tick();
        chk("t6d_rst_bus", {dc.Dcache_Req, dc.Dcache_Addr, dc.Dcache_WrData, dc.Dcache_WrStrb}, 69'd0);
        chk("t6d_rst_mem", {MEM_LdValid, MEM_Misalign, MEM_AccessFault, LSU_Stall, MEM_LdData, MEM_BadAddr}, 69'd0);
        rst = 1'b0;
        repeat (3) tick();
        chk("t6d_stall_low", {68'd0, LSU_Stall}, 69'd0);

        repeat (3) tick();
        chk("req_q_drained", 69'(req_q.size()), 69'd0);
        chk("ld_q_drained", 69'(ld_q.size()), 69'd0);
        chk("mis_q_drained", 69'(mis_q.size()), 69'd0);
        chk("flt_q_drained", 69'(flt_q.size()), 69'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
